// File: rtl/systolic_output_deskew_pkg.sv
// systolic_output_deskew_pkg
// Shared definitions for the systolic output deskew block.
//   DATA_WIDTH  : default bits per lane
//   state_e     : tile-sequencing FSM states
//   lane_delay  : number of alignment stages a given lane needs
package systolic_output_deskew_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Lane k arrives k cycles after lane 0, so it must wait (lanes-1-k)
    // cycles for the last lane of the same row to catch up.
    function automatic int lane_delay(input int lane, input int lanes);
        return lanes - 1 - lane;
    endfunction

endpackage

// File: rtl/systolic_output_deskew_if.sv
// systolic_output_deskew_if
// Bundles the deskew block's control, input word and status signals.
//   master : the producer/controller side (drives en/start/num_rows/valid/word in)
//   slave  : the deskew block itself (drives aligned word and status out)
interface systolic_output_deskew_if
    import systolic_output_deskew_pkg::*;
#(
    parameter int LANES  = 10,
    parameter int LANE_W = DATA_WIDTH,
    parameter int CNT_W  = 8
);
    logic                    en_i;
    logic                    start_i;
    logic [CNT_W-1:0]        num_rows_i;
    logic                    valid_i;
    logic [LANES*LANE_W-1:0] word_i;

    logic [LANES*LANE_W-1:0] word_o;
    logic                    valid_o;
    logic                    last_o;
    logic [CNT_W-1:0]        row_cnt_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    modport master (
        output en_i, start_i, num_rows_i, valid_i, word_i,
        input  word_o, valid_o, last_o, row_cnt_o, busy_o, done_o, err_o
    );

    modport slave (
        input  en_i, start_i, num_rows_i, valid_i, word_i,
        output word_o, valid_o, last_o, row_cnt_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/systolic_output_deskew_lane_delay.sv
// deskew_lane_delay
// DEPTH-stage shift register that only advances when en_i is high.
// DEPTH = 0 is a plain wire.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : advance enable
//   d_i / q_o     : data in / data delayed by DEPTH enabled cycles
module deskew_lane_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_ni, en_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];
        logic [W-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d = stage_q;
            if (en_i) begin
                stage_d[0] = d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
// Re-aligns a skewed systolic-array output word (lane k lags lane 0 by k
// cycles) so every lane of word_o belongs to the same row, and sequences
// one tile of num_rows rows with valid/last/done status.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : en_i, start_i, num_rows_i, valid_i, word_i in;
//                   word_o, valid_o, last_o, row_cnt_o, busy_o, done_o, err_o out
// LANES must be at least 2 so the last row is emitted after the FSM has
// left ACTIVE.
module systolic_output_deskew
    import systolic_output_deskew_pkg::*;
#(
    parameter int LANES  = 10,
    parameter int LANE_W = DATA_WIDTH,
    parameter int CNT_W  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    systolic_output_deskew_if.slave bus
);
    localparam int WW = LANES * LANE_W;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] num_rows_q, num_rows_d;
    logic [CNT_W-1:0] acc_cnt_q,  acc_cnt_d;
    logic [CNT_W-1:0] row_cnt_q,  row_cnt_d;
    logic             err_q,      err_d;

    logic              accept;
    logic              vld_out;
    logic              last_row;
    logic [LANE_W-1:0] lane_out [LANES];
    logic [WW-1:0]     word_s;

    // Only rows arriving while a tile is open enter the valid pipeline.
    assign accept = bus.valid_i && (state_q == ST_ACTIVE);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        deskew_lane_delay #(
            .DEPTH (lane_delay(k, LANES)),
            .W     (LANE_W)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (bus.en_i),
            .d_i    (bus.word_i[k*LANE_W +: LANE_W]),
            .q_o    (lane_out[k])
        );
    end

    // The valid pipeline matches lane 0's delay, so valid_o lines up with
    // the cycle in which the last lane of that row reaches word_o.
    deskew_lane_delay #(
        .DEPTH (LANES - 1),
        .W     (1)
    ) u_valid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (bus.en_i),
        .d_i    (accept),
        .q_o    (vld_out)
    );

    always_comb begin
        word_s = '0;
        for (int k = 0; k < LANES; k++) begin
            word_s[k*LANE_W +: LANE_W] = lane_out[k];
        end
    end

    assign last_row = vld_out && (row_cnt_q == num_rows_q - CNT_W'(1));

    // Tile sequencing; everything holds while en_i is low.
    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        acc_cnt_d  = acc_cnt_q;
        row_cnt_d  = row_cnt_q;
        err_d      = err_q;
        if (bus.en_i) begin
            if (vld_out) begin
                row_cnt_d = row_cnt_q + CNT_W'(1);
            end
            if (bus.valid_i && (state_q != ST_ACTIVE)) begin
                err_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        num_rows_d = bus.num_rows_i;
                        acc_cnt_d  = '0;
                        row_cnt_d  = '0;
                        // A stray row in the same cycle still flags an error.
                        err_d      = bus.valid_i;
                        state_d    = (bus.num_rows_i == '0) ? ST_DONE : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.valid_i) begin
                        acc_cnt_d = acc_cnt_q + CNT_W'(1);
                        if (acc_cnt_q + CNT_W'(1) == num_rows_q) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            num_rows_q <= '0;
            acc_cnt_q  <= '0;
            row_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            acc_cnt_q  <= acc_cnt_d;
            row_cnt_q  <= row_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.word_o    = word_s;
    assign bus.valid_o   = vld_out;
    assign bus.last_o    = last_row;
    assign bus.row_cnt_o = row_cnt_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.done_o    = (state_q == ST_DONE);
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb_systolic_output_deskew
// Self-checking bench: a matched input skewer feeds random rows, expected
// aligned rows go into a scoreboard and are popped when valid_o fires.
module tb_systolic_output_deskew;
    import systolic_output_deskew_pkg::*;

    localparam int LANES  = 10;
    localparam int LANE_W = DATA_WIDTH;
    localparam int CNT_W  = 8;
    localparam int WW     = LANES * LANE_W;
    localparam int LAT    = LANES - 1;

    typedef struct {
        logic [WW-1:0]    word;
        logic             last;
        logic [CNT_W-1:0] cnt;
        int               due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    systolic_output_deskew_if #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) bus ();

    systolic_output_deskew #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t          sb [$];
    logic [WW-1:0] hist [LANES];
    int            checks = 0;
    int            fails  = 0;
    int            ecnt   = 0;
    int            wcnt   = 0;
    bit            mon_on = 1'b0;

    // Skewer model: lane k of the driven word is lane k of the row driven
    // k enabled cycles earlier.
    function automatic logic [WW-1:0] skew(input logic [WW-1:0] row);
        logic [WW-1:0] w;
        w = row;
        for (int k = 1; k < LANES; k++) begin
            w[k*LANE_W +: LANE_W] = hist[k-1][k*LANE_W +: LANE_W];
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_row();
        logic [WW-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[k*LANE_W +: LANE_W] = LANE_W'($urandom);
        end
        return r;
    endfunction

    // One clock cycle of stimulus; called at posedge+2, returns at the next posedge+2.
    task automatic cycle(input logic en, input logic st, input logic [CNT_W-1:0] nr,
                         input logic v, input logic [WW-1:0] row);
        bus.en_i       = en;
        bus.start_i    = st;
        bus.num_rows_i = nr;
        bus.valid_i    = v;
        bus.word_i     = skew(row);
        @(posedge clk);
        if (en) begin
            for (int j = LANES - 1; j > 0; j--) begin
                hist[j] = hist[j-1];
            end
            hist[0] = row;
            ecnt++;
        end
        wcnt++;
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic applyStimulus(input int n);
        exp_t e;
        logic [WW-1:0] row;
        for (int r = 0; r < n; r++) begin
            row    = rand_row();
            e.word = row;
            e.last = (r == n - 1);
            e.cnt  = CNT_W'(r);
            e.due  = ecnt + LAT;
            sb.push_back(e);
            cycle(1'b1, 1'b0, '0, 1'b1, row);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.en_i       = 1'b0;
        bus.start_i    = 1'b0;
        bus.num_rows_i = '0;
        bus.valid_i    = 1'b0;
        bus.word_i     = '0;
        for (int j = 0; j < LANES; j++) begin
            hist[j] = '0;
        end
        sb.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int bound, output bit seen, output int last_w, output int done_w);
        seen   = 1'b0;
        last_w = -100;
        done_w = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            idle(1);
            if (bus.valid_o && bus.last_o) last_w = wcnt;
            if (bus.done_o) begin
                seen   = 1'b1;
                done_w = wcnt;
            end
        end
    endtask

    // Free-running word check plus scoreboard pop on every consumed valid_o.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            checks++;
            if (bus.word_o !== hist[LANES-2]) begin
                fails++;
                $display("[TB] FAIL word_o_stream: got %h expected %h", bus.word_o, hist[LANES-2]);
            end
            if (!bus.valid_o) begin
                checks++;
                if (bus.last_o !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL last_without_valid: got %b expected 0", bus.last_o);
                end
            end else if (rst_n && bus.en_i) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_valid_o: got 1 expected 0 at cycle %0d", wcnt);
                end else begin
                    e = sb.pop_front();
                    if (bus.word_o !== e.word) begin
                        fails++;
                        $display("[TB] FAIL row_word: got %h expected %h", bus.word_o, e.word);
                    end
                    checks++;
                    if (bus.last_o !== e.last) begin
                        fails++;
                        $display("[TB] FAIL last_o: got %b expected %b", bus.last_o, e.last);
                    end
                    checks++;
                    if (bus.row_cnt_o !== e.cnt) begin
                        fails++;
                        $display("[TB] FAIL row_cnt_o: got %0d expected %0d", bus.row_cnt_o, e.cnt);
                    end
                    checks++;
                    if (ecnt !== e.due) begin
                        fails++;
                        $display("[TB] FAIL latency: got %0d expected %0d", ecnt, e.due);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus.word_o, bus.valid_o, bus.last_o, bus.row_cnt_o, bus.busy_o, bus.done_o, bus.err_o} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got v=%b l=%b c=%0d b=%b d=%b e=%b w=%h expected all 0",
                     bus.valid_o, bus.last_o, bus.row_cnt_o, bus.busy_o, bus.done_o, bus.err_o, bus.word_o);
        end
        release_reset();
        mon_on = 1'b1;
        idle(2);
        checks++;
        if ({bus.word_o, bus.valid_o, bus.last_o, bus.row_cnt_o, bus.busy_o, bus.done_o, bus.err_o} !== '0) begin
            fails++;
            $display("[TB] FAIL post_reset_outputs: got v=%b c=%0d b=%b d=%b e=%b expected all 0",
                     bus.valid_o, bus.row_cnt_o, bus.busy_o, bus.done_o, bus.err_o);
        end
    endtask

    task automatic test_tile3();
        bit seen;
        int last_w, done_w;
        cycle(1'b1, 1'b1, CNT_W'(3), 1'b0, '0);
        checks++;
        if (bus.busy_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL tile3_busy: got %b expected 1", bus.busy_o);
        end
        applyStimulus(3);
        wait_done(40, seen, last_w, done_w);
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL tile3_done_timeout: got no done_o expected done_o within 40 cycles");
        end
        checks++;
        if (done_w !== last_w + 1) begin
            fails++;
            $display("[TB] FAIL tile3_done_after_last: got cycle %0d expected %0d", done_w, last_w + 1);
        end
        checks++;
        if (bus.row_cnt_o !== CNT_W'(3)) begin
            fails++;
            $display("[TB] FAIL tile3_row_cnt: got %0d expected 3", bus.row_cnt_o);
        end
        idle(1);
        checks++;
        if ({bus.done_o, bus.busy_o} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL tile3_back_to_idle: got done=%b busy=%b expected 0 0", bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_stall_drain();
        bit seen;
        int last_w, done_w, w0, vw;
        cycle(1'b1, 1'b1, CNT_W'(2), 1'b0, '0);
        w0 = wcnt;
        applyStimulus(2);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            checks++;
            if ({bus.valid_o, bus.row_cnt_o, bus.busy_o} !== {1'b0, CNT_W'(0), 1'b1}) begin
                fails++;
                $display("[TB] FAIL stall_freeze: got valid=%b cnt=%0d busy=%b expected 0 0 1",
                         bus.valid_o, bus.row_cnt_o, bus.busy_o);
            end
        end
        vw = -1;
        for (int i = 0; i < 30 && vw < 0; i++) begin
            idle(1);
            if (bus.valid_o) vw = wcnt;
        end
        checks++;
        if (vw - w0 !== LAT + 4) begin
            fails++;
            $display("[TB] FAIL stall_latency: got %0d expected %0d", vw - w0, LAT + 4);
        end
        wait_done(40, seen, last_w, done_w);
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL stall_done_timeout: got no done_o expected done_o within 40 cycles");
        end
        idle(1);
    endtask

    task automatic test_error();
        bit seen;
        int last_w, done_w;
        cycle(1'b1, 1'b0, '0, 1'b1, rand_row());
        checks++;
        if (bus.err_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_set: got %b expected 1", bus.err_o);
        end
        idle(12);
        checks++;
        if (bus.err_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_sticky: got %b expected 1", bus.err_o);
        end
        cycle(1'b1, 1'b1, CNT_W'(1), 1'b0, '0);
        checks++;
        if (bus.err_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_clear_on_start: got %b expected 0", bus.err_o);
        end
        applyStimulus(1);
        wait_done(40, seen, last_w, done_w);
        checks++;
        if (!seen || done_w !== last_w + 1) begin
            fails++;
            $display("[TB] FAIL tile1_done: got seen=%b cycle %0d expected cycle %0d", seen, done_w, last_w + 1);
        end
        idle(1);
    endtask

    task automatic test_zero_rows();
        cycle(1'b1, 1'b1, '0, 1'b0, '0);
        checks++;
        if ({bus.done_o, bus.busy_o} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL zero_rows_done: got done=%b busy=%b expected 1 1", bus.done_o, bus.busy_o);
        end
        idle(1);
        checks++;
        if ({bus.done_o, bus.busy_o} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL zero_rows_idle: got done=%b busy=%b expected 0 0", bus.done_o, bus.busy_o);
        end
        idle(12);
    endtask

    task automatic test_reset_mid_tile();
        bit reached;
        cycle(1'b1, 1'b1, CNT_W'(5), 1'b0, '0);
        applyStimulus(5);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            idle(1);
            if (sb.size() == 3) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            fails++;
            $display("[TB] FAIL mid_tile_rows: got %0d pending expected 3", sb.size());
        end
        do_reset();
        #1;
        checks++;
        if ({bus.word_o, bus.valid_o, bus.last_o, bus.row_cnt_o, bus.busy_o, bus.done_o, bus.err_o} !== '0) begin
            fails++;
            $display("[TB] FAIL mid_tile_reset_outputs: got v=%b c=%0d b=%b d=%b e=%b expected all 0",
                     bus.valid_o, bus.row_cnt_o, bus.busy_o, bus.done_o, bus.err_o);
        end
        release_reset();
        idle(20);
        checks++;
        if ({bus.valid_o, bus.row_cnt_o, bus.busy_o, bus.done_o} !== '0) begin
            fails++;
            $display("[TB] FAIL mid_tile_after_release: got v=%b c=%0d b=%b d=%b expected all 0",
                     bus.valid_o, bus.row_cnt_o, bus.busy_o, bus.done_o);
        end
    endtask

    initial begin
        test_reset();
        test_tile3();
        test_stall_drain();
        test_error();
        test_zero_rows();
        test_reset_mid_tile();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_leftover: got %0d rows expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end
endmodule
